// File: rtl/studio2_keypad_pkg.sv
// Shared constants for the Studio II keypad front end: PS/2 event layout,
// scancode-to-digit tables and the keypad digit select width.
package studio2_keypad_pkg;

  localparam int KEYS_PER_PAD = 10;
  localparam int SEL_W        = 4;

  localparam int PS2_STROBE_BIT = 10;
  localparam int PS2_MAKE_BIT   = 9;
  localparam int PS2_EXT_BIT    = 8;
  localparam int PS2_CODE_MSB   = 7;

  typedef logic [KEYS_PER_PAD-1:0][7:0] code_table_t;

  // Entry n is the scancode of keypad digit n (packed, digit 9 written first).
  localparam code_table_t KP1_CODES = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };
  localparam code_table_t KP2_CODES = {
    8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73, 8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70
  };

  function automatic logic [KEYS_PER_PAD-1:0] decode_code(
    input logic [7:0]  code,
    input code_table_t table_codes
  );
    logic [KEYS_PER_PAD-1:0] hits;
    hits = '0;
    for (int i = 0; i < KEYS_PER_PAD; i++) begin
      hits[i] = (code == table_codes[i]);
    end
    return hits;
  endfunction

endpackage

// File: rtl/studio2_key_cell.sv
// One keypad key: pressed flag, saturating frame-age counter and a pending
// release that enforces a minimum visible hold of MIN_FRAMES frames.
module studio2_key_cell
  import studio2_keypad_pkg::*;
#(
  parameter int MIN_FRAMES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic make,
  input  logic brk,
  input  logic tick,
  output logic pressed
);

  localparam logic [1:0] MIN_AGE = 2'(MIN_FRAMES);

  logic       pressed_q, pressed_d;
  logic [1:0] age_q, age_d;
  logic       pending_q, pending_d;
  logic [1:0] age_inc;
  logic       hold_done;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pressed_d = pressed_q;
    age_d     = age_q;
    pending_d = pending_q;

    age_inc   = (tick && pressed_q && (age_q < MIN_AGE)) ? age_q + 2'd1 : age_q;
    // Decisions use the age before this cycle's tick increment.
    hold_done = !(age_q < MIN_AGE);

    if (make) begin
      if (!pressed_q) begin
        pressed_d = 1'b1;
        age_d     = 2'd0;
        pending_d = 1'b0;
      end else begin
        age_d     = age_inc;
        pending_d = 1'b0;
      end
    end else if (brk && pressed_q) begin
      if (hold_done) begin
        pressed_d = 1'b0;
        age_d     = 2'd0;
        pending_d = 1'b0;
      end else begin
        age_d     = age_inc;
        pending_d = 1'b1;
      end
    end else if (pending_q && hold_done) begin
      pressed_d = 1'b0;
      age_d     = 2'd0;
      pending_d = 1'b0;
    end else begin
      age_d = age_inc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments with an async clear on reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pressed_q <= 1'b0;
      age_q     <= 2'd0;
      pending_q <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
      age_q     <= age_d;
      pending_q <= pending_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/studio2_keypad.sv
// RCA Studio II dual keypad emulation from PS/2 events: decodes scancodes into
// 20 key cells and presents the CPU-selected digit on EF3/EF4.
module studio2_keypad
  import studio2_keypad_pkg::*;
#(
  parameter int MIN_FRAMES = 2
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [10:0]             ps2_key,
  input  logic                    frame_tick,
  input  logic                    sel_wr,
  input  logic [SEL_W-1:0]        sel_data,
  output logic                    ef3,
  output logic                    ef4,
  output logic [KEYS_PER_PAD-1:0] keys1,
  output logic [KEYS_PER_PAD-1:0] keys2
);

  logic             strobe_q, strobe_d;
  logic             primed_q, primed_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ef3_q, ef3_d;
  logic             ef4_q, ef4_d;

  logic                    evt_valid;
  logic [KEYS_PER_PAD-1:0] hit1, hit2;
  logic [KEYS_PER_PAD-1:0] make1, make2, brk1, brk2;

  always_comb begin
    strobe_d = ps2_key[PS2_STROBE_BIT];
    primed_d = 1'b1;
    sel_d    = sel_wr ? sel_data : sel_q;

    // The first cycle out of reset only primes the strobe copy.
    evt_valid = primed_q && (ps2_key[PS2_STROBE_BIT] != strobe_q)
                && !ps2_key[PS2_EXT_BIT];
    hit1 = decode_code(ps2_key[PS2_CODE_MSB:0], KP1_CODES);
    hit2 = decode_code(ps2_key[PS2_CODE_MSB:0], KP2_CODES);

    make1 = '0;
    make2 = '0;
    brk1  = '0;
    brk2  = '0;
    if (evt_valid) begin
      if (ps2_key[PS2_MAKE_BIT]) begin
        make1 = hit1;
        make2 = hit2;
      end else begin
        brk1 = hit1;
        brk2 = hit2;
      end
    end

    ef3_d = 1'b0;
    ef4_d = 1'b0;
    if (sel_q < SEL_W'(KEYS_PER_PAD)) begin
      ef3_d = keys1[sel_q];
      ef4_d = keys2[sel_q];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      primed_q <= 1'b0;
      sel_q    <= '0;
      ef3_q    <= 1'b0;
      ef4_q    <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      primed_q <= primed_d;
      sel_q    <= sel_d;
      ef3_q    <= ef3_d;
      ef4_q    <= ef4_d;
    end
  end

  for (genvar i = 0; i < KEYS_PER_PAD; i++) begin : g_keys
    studio2_key_cell #(.MIN_FRAMES(MIN_FRAMES)) u_key1 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .make    (make1[i]),
      .brk     (brk1[i]),
      .tick    (frame_tick),
      .pressed (keys1[i])
    );
    studio2_key_cell #(.MIN_FRAMES(MIN_FRAMES)) u_key2 (
      .clk_sys (clk_sys),
      .reset   (reset),
      .make    (make2[i]),
      .brk     (brk2[i]),
      .tick    (frame_tick),
      .pressed (keys2[i])
    );
  end

  assign ef3 = ef3_q;
  assign ef4 = ef4_q;

endmodule

// File: tb/tb_studio2_keypad.sv
// Directed bench for studio2_keypad: reset priming, decode, minimum hold,
// break/tick ordering, ignored events, select boundaries and mid-hold reset.
module tb_studio2_keypad;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        frame_tick;
  logic        sel_wr;
  logic [3:0]  sel_data;
  logic        ef3, ef4;
  logic [9:0]  keys1, keys2;
  logic        ef3_z, ef4_z;
  logic [9:0]  keys1_z, keys2_z;

  logic        tog;
  int          checks = 0;
  int          failures = 0;

  logic [7:0] kp1 [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  always #5 clk_sys = ~clk_sys;

  studio2_keypad #(.MIN_FRAMES(2)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .frame_tick(frame_tick),
    .sel_wr(sel_wr), .sel_data(sel_data), .ef3(ef3), .ef4(ef4), .keys1(keys1), .keys2(keys2)
  );

  studio2_keypad #(.MIN_FRAMES(0)) u_dut_z (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .frame_tick(frame_tick),
    .sel_wr(sel_wr), .sel_data(sel_data), .ef3(ef3_z), .ef4(ef4_z), .keys1(keys1_z), .keys2(keys2_z)
  );

  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic send(input logic mk, input logic ext, input logic [7:0] code, input logic tick);
    tog        = ~tog;
    ps2_key    = {tog, mk, ext, code};
    frame_tick = tick;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tog = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
    step();
    step();
    checks++;
    if (keys1 !== 10'h000) begin
      failures++;
      $display("FAIL reset_in_keys1 got=%h exp=000", keys1);
    end
    reset = 1'b0;
    step();
    step();
    checks++;
    if (keys1 !== 10'h000) begin
      failures++;
      $display("FAIL reset_prime_keys1 got=%h exp=000", keys1);
    end
    checks++;
    if (keys2 !== 10'h000) begin
      failures++;
      $display("FAIL reset_prime_keys2 got=%h exp=000", keys2);
    end
    checks++;
    if (ef3 !== 1'b0 || ef4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ef got=%b%b exp=00", ef3, ef4);
    end
  endtask

  task automatic test_make_select();
    do_reset();
    sel_wr = 1'b1;
    sel_data = 4'd1;
    send(1'b1, 1'b0, 8'h16, 1'b0);
    sel_wr = 1'b0;
    checks++;
    if (keys1 !== 10'h002) begin
      failures++;
      $display("FAIL make_keys1 got=%h exp=002", keys1);
    end
    checks++;
    if (ef3 !== 1'b0) begin
      failures++;
      $display("FAIL ef3_latency got=%b exp=0", ef3);
    end
    step();
    checks++;
    if (ef3 !== 1'b1 || ef4 !== 1'b0) begin
      failures++;
      $display("FAIL ef_select got=%b%b exp=10", ef3, ef4);
    end
  endtask

  task automatic test_min_hold();
    do_reset();
    send(1'b1, 1'b0, 8'h73, 1'b0);
    checks++;
    if (keys2 !== 10'h020) begin
      failures++;
      $display("FAIL hold_make got=%h exp=020", keys2);
    end
    send(1'b0, 1'b0, 8'h73, 1'b0);
    step();
    step();
    checks++;
    if (keys2 !== 10'h020) begin
      failures++;
      $display("FAIL hold_pending got=%h exp=020", keys2);
    end
    checks++;
    if (keys2_z !== 10'h000) begin
      failures++;
      $display("FAIL zero_min_break got=%h exp=000", keys2_z);
    end
    tick_frame();
    step();
    checks++;
    if (keys2 !== 10'h020) begin
      failures++;
      $display("FAIL hold_tick1 got=%h exp=020", keys2);
    end
    tick_frame();
    step();
    checks++;
    if (keys2 !== 10'h000) begin
      failures++;
      $display("FAIL hold_release got=%h exp=000", keys2);
    end
  endtask

  task automatic test_break_with_tick();
    do_reset();
    send(1'b1, 1'b0, 8'h70, 1'b0);
    tick_frame();
    tick_frame();
    send(1'b0, 1'b0, 8'h70, 1'b1);
    checks++;
    if (keys2 !== 10'h000) begin
      failures++;
      $display("FAIL brk_tick_aged got=%h exp=000", keys2);
    end
    send(1'b1, 1'b0, 8'h70, 1'b0);
    tick_frame();
    send(1'b0, 1'b0, 8'h70, 1'b1);
    checks++;
    if (keys2 !== 10'h001) begin
      failures++;
      $display("FAIL brk_tick_preage got=%h exp=001", keys2);
    end
    step();
    checks++;
    if (keys2 !== 10'h000) begin
      failures++;
      $display("FAIL brk_tick_late got=%h exp=000", keys2);
    end
    send(1'b1, 1'b0, 8'h70, 1'b0);
    send(1'b0, 1'b0, 8'h70, 1'b0);
    send(1'b1, 1'b0, 8'h70, 1'b0);
    tick_frame();
    tick_frame();
    step();
    step();
    checks++;
    if (keys2 !== 10'h001) begin
      failures++;
      $display("FAIL remake_pending got=%h exp=001", keys2);
    end
    send(1'b1, 1'b0, 8'h70, 1'b0);
    send(1'b0, 1'b0, 8'h70, 1'b0);
    checks++;
    if (keys2 !== 10'h000) begin
      failures++;
      $display("FAIL repeat_keeps_age got=%h exp=000", keys2);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    send(1'b1, 1'b0, 8'h16, 1'b0);
    send(1'b1, 1'b1, 8'h70, 1'b0);
    send(1'b1, 1'b0, 8'h1C, 1'b0);
    send(1'b0, 1'b0, 8'h45, 1'b0);
    checks++;
    if (keys1 !== 10'h002 || keys2 !== 10'h000) begin
      failures++;
      $display("FAIL ignored_events got=%h/%h exp=002/000", keys1, keys2);
    end
    send(1'b1, 1'b0, 8'h46, 1'b0);
    send(1'b1, 1'b0, 8'h7D, 1'b0);
    sel_wr = 1'b1;
    sel_data = 4'd9;
    step();
    sel_wr = 1'b0;
    step();
    checks++;
    if (ef3 !== 1'b1 || ef4 !== 1'b1) begin
      failures++;
      $display("FAIL sel9 got=%b%b exp=11", ef3, ef4);
    end
    sel_wr = 1'b1;
    sel_data = 4'd12;
    step();
    sel_wr = 1'b0;
    step();
    checks++;
    if (ef3 !== 1'b0 || ef4 !== 1'b0) begin
      failures++;
      $display("FAIL sel12 got=%b%b exp=00", ef3, ef4);
    end
  endtask

  task automatic test_reset_midhold();
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0, kp1[i], 1'b0);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0, kp1[i], 1'b0);
    checks++;
    if (keys1 !== 10'h3FF) begin
      failures++;
      $display("FAIL all_pending got=%h exp=3ff", keys1);
    end
    sel_wr = 1'b1;
    sel_data = 4'd9;
    step();
    sel_wr = 1'b0;
    step();
    checks++;
    if (ef3 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_ef3 got=%b exp=1", ef3);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (keys1 !== 10'h000 || keys2 !== 10'h000 || ef3 !== 1'b0 || ef4 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%h ef=%b%b exp=000/000 ef=00", keys1, keys2, ef3, ef4);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    step();
    tick_frame();
    tick_frame();
    step();
    step();
    checks++;
    if (keys1 !== 10'h000) begin
      failures++;
      $display("FAIL post_reset_quiet got=%h exp=000", keys1);
    end
    send(1'b1, 1'b0, 8'h45, 1'b0);
    step();
    checks++;
    if (keys1 !== 10'h001 || ef3 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_sel0 got=%h ef3=%b exp=001 ef3=1", keys1, ef3);
    end
  endtask

  initial begin
    reset = 1'b1;
    tog = 1'b0;
    ps2_key = '0;
    frame_tick = 1'b0;
    sel_wr = 1'b0;
    sel_data = '0;
    @(negedge clk_sys);
    test_reset();
    test_make_select();
    test_min_hold();
    test_break_with_tick();
    test_ignored();
    test_reset_midhold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
